// File: rtl/game_sequencer_if.sv
// game_sequencer_if
// Bundles the control pulses, datapath status levels and sequencer outputs
// into one interface.
//   btn_power/btn_ok/btn_next/btn_pause : one-cycle debounced button pulses
//   collision/goal                      : status levels from the obstacle datapath
//   presente[2:0]                       : current state code
//   hero_sel[1:0]                       : selected hero index
//   game_run/game_start/result          : game control and outcome
// The master modport drives the inputs (board/testbench side).
// The slave modport is the sequencer itself.
interface game_sequencer_if;
  logic       btn_power;
  logic       btn_ok;
  logic       btn_next;
  logic       btn_pause;
  logic       collision;
  logic       goal;
  logic [2:0] presente;
  logic [1:0] hero_sel;
  logic       game_run;
  logic       game_start;
  logic       result;

  modport master (
    output btn_power, btn_ok, btn_next, btn_pause, collision, goal,
    input  presente, hero_sel, game_run, game_start, result
  );

  modport slave (
    input  btn_power, btn_ok, btn_next, btn_pause, collision, goal,
    output presente, hero_sel, game_run, game_start, result
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
// Top-level state machine for the runner game:
// OFF -> WLCM -> CH -> GAME <-> PA, GAME -> WL -> CH.
// Every output is a flop, so there is no combinational path from input to output.
//   clk   : system clock; all state changes happen on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : game_sequencer_if slave (buttons, datapath levels, outputs)
// Parameters:
//   TICK_DIV   : clk cycles per timing tick (minimum 2)
//   WLCM_TICKS : ticks the welcome screen is held
//   WL_TICKS   : ticks the win/lose screen is held
module game_sequencer #(
  parameter int TICK_DIV   = 27000,
  parameter int WLCM_TICKS = 3,
  parameter int WL_TICKS   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  game_sequencer_if.slave  bus
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int MAXT = (WLCM_TICKS > WL_TICKS) ? WLCM_TICKS : WL_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    WLCM = 3'd1,
    CH   = 3'd2,
    GAME = 3'd3,
    WL   = 3'd4,
    PA   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    hero_q, hero_d;
  logic          run_q, run_d;
  logic          start_q, start_d;
  logic          result_q, result_d;
  logic          presc_last;

  // The state, the timer and the output flops all reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      presc_q  <= '0;
      tick_q   <= '0;
      hero_q   <= 2'd0;
      run_q    <= 1'b0;
      start_q  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      hero_q   <= hero_d;
      run_q    <= run_d;
      start_q  <= start_d;
      result_q <= result_d;
    end
  end

  assign presc_last = (presc_q == PW'(TICK_DIV - 1));

  // Compute the next state and the next value of every output.
  // The prescaler and the tick counter run freely within a state and are
  // cleared on every state change. A timed state therefore leaves on the
  // edge where the last prescaler count of its last tick is seen.
  always_comb begin
    state_d  = state_q;
    hero_d   = hero_q;
    result_d = result_q;
    start_d  = 1'b0;
    presc_d  = presc_last ? '0 : presc_q + PW'(1);
    tick_d   = presc_last ? tick_q + TW'(1) : tick_q;

    if (bus.btn_power) begin
      state_d = (state_q == OFF) ? WLCM : OFF;
    end else begin
      case (state_q)
        OFF: ;
        WLCM: begin
          if (presc_last && tick_q == TW'(WLCM_TICKS - 1)) state_d = CH;
        end
        CH: begin
          // When ok and next arrive together, ok wins and the hero is kept.
          if (bus.btn_ok) begin
            state_d = GAME;
            start_d = 1'b1;
          end else if (bus.btn_next) begin
            hero_d = (hero_q == 2'd2) ? 2'd0 : hero_q + 2'd1;
          end
        end
        GAME: begin
          if (bus.collision) begin
            state_d  = WL;
            result_d = 1'b0;
          end else if (bus.goal) begin
            state_d  = WL;
            result_d = 1'b1;
          end else if (bus.btn_pause) begin
            state_d = PA;
          end
        end
        WL: begin
          if (bus.btn_ok || (presc_last && tick_q == TW'(WL_TICKS - 1))) state_d = CH;
        end
        PA: begin
          if (bus.btn_pause) state_d = GAME;
        end
        default: state_d = OFF;
      endcase
    end

    if (state_d != state_q) begin
      presc_d = '0;
      tick_d  = '0;
    end

    if (state_d == OFF) hero_d = 2'd0;

    run_d = (state_d == GAME);
  end

  assign bus.presente   = state_q;
  assign bus.hero_sel   = hero_q;
  assign bus.game_run   = run_q;
  assign bus.game_start = start_q;
  assign bus.result     = result_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
// Directed testbench for game_sequencer with TICK_DIV=4, WLCM_TICKS=2 and
// WL_TICKS=3. Inputs change 1 time unit after a rising edge. Outputs are
// sampled at the same point, after the edge has taken effect.
module tb_game_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  game_sequencer_if bus ();

  game_sequencer #(
    .TICK_DIV   (4),
    .WLCM_TICKS (2),
    .WL_TICKS   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Pulse the selected buttons for exactly one clock edge.
  // The bits of btns are {pause, next, ok, power}.
  task automatic applyStimulus(input logic [3:0] btns);
    {bus.btn_pause, bus.btn_next, bus.btn_ok, bus.btn_power} = btns;
    @(posedge clk);
    #1;
    {bus.btn_pause, bus.btn_next, bus.btn_ok, bus.btn_power} = 4'b0000;
  endtask

  // Let n edges pass, then stop just after the last one.
  task automatic tickCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] POWER = 4'b0001;
  localparam logic [3:0] OK    = 4'b0010;
  localparam logic [3:0] NEXT  = 4'b0100;
  localparam logic [3:0] PAUSE = 4'b1000;

  // Directed sequence: reset, power-up, hero selection, pause, win with
  // early exit, simultaneous collision and goal, next+ok together,
  // power-off, and asynchronous reset.
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.btn_power = 1'b0;
    bus.btn_ok    = 1'b0;
    bus.btn_next  = 1'b0;
    bus.btn_pause = 1'b0;
    bus.collision = 1'b0;
    bus.goal      = 1'b0;

    #23;
    checkOutput("rst_presente", 8'(bus.presente), 8'd0);
    checkOutput("rst_hero", 8'(bus.hero_sel), 8'd0);
    checkOutput("rst_run", 8'(bus.game_run), 8'd0);
    checkOutput("rst_start", 8'(bus.game_start), 8'd0);
    checkOutput("rst_result", 8'(bus.result), 8'd0);
    rst_n = 1'b1;
    tickCycles(2);
    checkOutput("idle_off", 8'(bus.presente), 8'd0);

    // Power-up: WLCM on the next edge, then CH 8 cycles later; ok is ignored.
    applyStimulus(POWER);
    checkOutput("pwr_wlcm", 8'(bus.presente), 8'd1);
    applyStimulus(OK);
    checkOutput("wlcm_ok_ignored", 8'(bus.presente), 8'd1);
    tickCycles(6);
    checkOutput("wlcm_hold7", 8'(bus.presente), 8'd1);
    tickCycles(1);
    checkOutput("wlcm_to_ch", 8'(bus.presente), 8'd2);

    // Hero selection: four next pulses give 1,2,0,1; ok enters GAME.
    applyStimulus(NEXT);
    checkOutput("hero_1", 8'(bus.hero_sel), 8'd1);
    applyStimulus(NEXT);
    checkOutput("hero_2", 8'(bus.hero_sel), 8'd2);
    applyStimulus(NEXT);
    checkOutput("hero_wrap0", 8'(bus.hero_sel), 8'd0);
    applyStimulus(NEXT);
    checkOutput("hero_1b", 8'(bus.hero_sel), 8'd1);
    applyStimulus(OK);
    checkOutput("game_presente", 8'(bus.presente), 8'd3);
    checkOutput("game_start_hi", 8'(bus.game_start), 8'd1);
    checkOutput("game_run_hi", 8'(bus.game_run), 8'd1);
    tickCycles(1);
    checkOutput("game_start_lo", 8'(bus.game_start), 8'd0);
    checkOutput("game_stays", 8'(bus.presente), 8'd3);

    // Pause: collision held while paused has no effect; resume gives no start pulse.
    applyStimulus(PAUSE);
    checkOutput("pa_presente", 8'(bus.presente), 8'd5);
    checkOutput("pa_run", 8'(bus.game_run), 8'd0);
    bus.collision = 1'b1;
    tickCycles(3);
    checkOutput("pa_collision_ignored", 8'(bus.presente), 8'd5);
    bus.collision = 1'b0;
    applyStimulus(PAUSE);
    checkOutput("resume_presente", 8'(bus.presente), 8'd3);
    checkOutput("resume_no_start", 8'(bus.game_start), 8'd0);
    checkOutput("resume_run", 8'(bus.game_run), 8'd1);

    // Win, then leave WL early with ok two cycles later.
    bus.goal = 1'b1;
    tickCycles(1);
    bus.goal = 1'b0;
    checkOutput("win_presente", 8'(bus.presente), 8'd4);
    checkOutput("win_result", 8'(bus.result), 8'd1);
    checkOutput("win_run", 8'(bus.game_run), 8'd0);
    tickCycles(1);
    applyStimulus(OK);
    checkOutput("wl_early_exit", 8'(bus.presente), 8'd2);
    checkOutput("wl_exit_result", 8'(bus.result), 8'd1);
    checkOutput("hero_retained", 8'(bus.hero_sel), 8'd1);

    // Collision and goal together: collision wins; WL lasts 12 cycles.
    applyStimulus(OK);
    checkOutput("game2_start", 8'(bus.game_start), 8'd1);
    bus.collision = 1'b1;
    bus.goal      = 1'b1;
    tickCycles(1);
    bus.collision = 1'b0;
    bus.goal      = 1'b0;
    checkOutput("lose_presente", 8'(bus.presente), 8'd4);
    checkOutput("lose_result", 8'(bus.result), 8'd0);
    checkOutput("lose_run", 8'(bus.game_run), 8'd0);
    tickCycles(11);
    checkOutput("wl_hold11", 8'(bus.presente), 8'd4);
    tickCycles(1);
    checkOutput("wl_timeout_ch", 8'(bus.presente), 8'd2);
    checkOutput("wl_timeout_result", 8'(bus.result), 8'd0);

    // next and ok together: enter GAME and keep the hero.
    applyStimulus(NEXT | OK);
    checkOutput("nextok_presente", 8'(bus.presente), 8'd3);
    checkOutput("nextok_hero", 8'(bus.hero_sel), 8'd1);
    checkOutput("nextok_start", 8'(bus.game_start), 8'd1);

    // Power-off from GAME clears the hero.
    applyStimulus(POWER);
    checkOutput("poff_presente", 8'(bus.presente), 8'd0);
    checkOutput("poff_hero", 8'(bus.hero_sel), 8'd0);
    checkOutput("poff_run", 8'(bus.game_run), 8'd0);

    // Asynchronous reset in the middle of WLCM, between clock edges.
    applyStimulus(POWER);
    checkOutput("wlcm2_presente", 8'(bus.presente), 8'd1);
    tickCycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_presente", 8'(bus.presente), 8'd0);
    checkOutput("async_hero", 8'(bus.hero_sel), 8'd0);
    checkOutput("async_run", 8'(bus.game_run), 8'd0);
    checkOutput("async_start", 8'(bus.game_start), 8'd0);
    checkOutput("async_result", 8'(bus.result), 8'd0);
    tickCycles(1);
    rst_n = 1'b1;
    tickCycles(1);
    checkOutput("post_rst_off", 8'(bus.presente), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
